// File: rtl/usb_rx_ctrl.sv
// usb_rx_ctrl: receive-side sequencer for the USB full-speed packet receiver.
// Counts decoded bits into bytes, validates SYNC and PID, strobes each data
// byte into the RX FIFO and flags framing, PID and length errors.
module usb_rx_ctrl #(
  parameter int MAX_BYTES = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_edge,
  input  logic       shift_enable,
  input  logic       eop,
  input  logic [7:0] rcv_data,
  output logic       rcving,
  output logic       w_enable,
  output logic       r_error,
  output logic [3:0] rx_pid,
  output logic       pid_valid
);

  localparam int CNT_W = $clog2(MAX_BYTES + 1);

  typedef enum logic [3:0] {
    IDLE,
    SYNC,
    CHK_SYNC,
    PID,
    CHK_PID,
    DATA,
    STORE,
    EOP_WAIT,
    ERR_WAIT
  } state_t;

  state_t             r_state;
  logic [2:0]         r_bit_cnt;
  logic               r_byte_done;
  logic [CNT_W-1:0]   r_byte_cnt;
  logic               r_rcving;
  logic               r_wen;
  logic               r_err;
  logic [3:0]         r_pid;
  logic               r_pid_valid;

  logic w_bit_state;
  logic w_bit_tick;
  logic w_eop_strobe;
  logic w_sync_ok;
  logic w_pid_ok;
  logic w_cnt_full;

  // Bits are only counted while a byte is being assembled; an SE0 sample is
  // never a data bit.
  assign w_bit_state  = (r_state == SYNC) || (r_state == PID) || (r_state == DATA);
  assign w_bit_tick   = w_bit_state && shift_enable && !eop;
  assign w_eop_strobe = shift_enable && eop;
  assign w_sync_ok    = (rcv_data == 8'h80);
  assign w_pid_ok     = (rcv_data[3:0] == ~rcv_data[7:4]);
  assign w_cnt_full   = (r_byte_cnt == CNT_W'(MAX_BYTES));

  // Bit counter and the registered end-of-byte flag (one cycle after the 8th bit).
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_bit_cnt   <= 3'd0;
      r_byte_done <= 1'b0;
    end else begin
      r_byte_done <= w_bit_tick && (r_bit_cnt == 3'd7);
      if (r_state == IDLE) begin
        r_bit_cnt <= 3'd0;
      end else if (w_bit_tick) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
    end
  end

  // Packet sequencer with registered status outputs and byte counter.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= IDLE;
      r_byte_cnt  <= '0;
      r_rcving    <= 1'b0;
      r_wen       <= 1'b0;
      r_err       <= 1'b0;
      r_pid       <= 4'h0;
      r_pid_valid <= 1'b0;
    end else begin
      r_wen       <= 1'b0;
      r_pid_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          r_byte_cnt <= '0;
          if (d_edge) begin
            r_state  <= SYNC;
            r_rcving <= 1'b1;
            r_err    <= 1'b0;
          end
        end
        SYNC: begin
          if (r_byte_done) begin
            r_state <= CHK_SYNC;
          end else if (w_eop_strobe) begin
            r_state <= ERR_WAIT;
            r_err   <= 1'b1;
          end
        end
        CHK_SYNC: begin
          if (w_sync_ok) begin
            r_state <= PID;
          end else begin
            r_state <= ERR_WAIT;
            r_err   <= 1'b1;
          end
        end
        PID: begin
          if (r_byte_done) begin
            r_state <= CHK_PID;
          end else if (w_eop_strobe) begin
            r_state <= ERR_WAIT;
            r_err   <= 1'b1;
          end
        end
        CHK_PID: begin
          if (w_pid_ok) begin
            r_state     <= DATA;
            r_pid       <= rcv_data[3:0];
            r_pid_valid <= 1'b1;
          end else begin
            r_state <= ERR_WAIT;
            r_err   <= 1'b1;
          end
        end
        DATA: begin
          if (r_byte_done) begin
            // Write strobe is raised together with entry to STORE so it is
            // registered; a full buffer never produces the strobe.
            r_state <= STORE;
            r_wen   <= !w_cnt_full;
          end else if (w_eop_strobe) begin
            if (r_bit_cnt == 3'd0) begin
              r_state <= EOP_WAIT;
            end else begin
              r_state <= ERR_WAIT;
              r_err   <= 1'b1;
            end
          end
        end
        STORE: begin
          if (w_cnt_full) begin
            r_state <= ERR_WAIT;
            r_err   <= 1'b1;
          end else begin
            r_state    <= DATA;
            r_byte_cnt <= r_byte_cnt + CNT_W'(1);
          end
        end
        EOP_WAIT: begin
          if (!eop) begin
            r_state  <= IDLE;
            r_rcving <= 1'b0;
          end
        end
        ERR_WAIT: begin
          if (w_eop_strobe) begin
            r_state <= EOP_WAIT;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign rcving    = r_rcving;
  assign w_enable  = r_wen;
  assign r_error   = r_err;
  assign rx_pid    = r_pid;
  assign pid_valid = r_pid_valid;

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// Bench for usb_rx_ctrl: drives directed packets bit by bit and compares every
// output, every cycle, against a timeline derived from the packet contents.
module tb_usb_rx_ctrl;

  localparam int MAX  = 4;
  localparam int NC   = 8192;
  localparam int BITP = 8;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       d_edge = 1'b0;
  logic       shift_enable = 1'b0;
  logic       eop = 1'b0;
  logic [7:0] rcv_data = 8'hFF;
  logic       rcving;
  logic       w_enable;
  logic       r_error;
  logic [3:0] rx_pid;
  logic       pid_valid;

  usb_rx_ctrl #(.MAX_BYTES(MAX)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .d_edge       (d_edge),
    .shift_enable (shift_enable),
    .eop          (eop),
    .rcv_data     (rcv_data),
    .rcving       (rcving),
    .w_enable     (w_enable),
    .r_error      (r_error),
    .rx_pid       (rx_pid),
    .pid_valid    (pid_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Expected output timeline, indexed by cycle number.
  bit         e_rcv [NC];
  bit         e_err [NC];
  bit         e_wen [NC];
  bit         e_pv  [NC];
  logic [3:0] e_pid [NC];

  logic [7:0] pkt [16];
  logic [7:0] cap [$];
  int         wcnt = 0;
  int         pvcnt = 0;
  bit         chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int sk(input int td, input int k);
    return td + 4 + BITP * k;
  endfunction

  // Per-cycle compare against the timeline, plus capture of written bytes.
  initial begin
    forever begin
      @(negedge clk);
      if (w_enable) begin
        cap.push_back(rcv_data);
        wcnt++;
      end
      if (pid_valid) pvcnt++;
      if (chk_en && cyc < NC) begin
        chk($sformatf("rcving@%0d", cyc),    32'(rcving),    32'(e_rcv[cyc]));
        chk($sformatf("w_enable@%0d", cyc),  32'(w_enable),  32'(e_wen[cyc]));
        chk($sformatf("r_error@%0d", cyc),   32'(r_error),   32'(e_err[cyc]));
        chk($sformatf("pid_valid@%0d", cyc), 32'(pid_valid), 32'(e_pv[cyc]));
        chk($sformatf("rx_pid@%0d", cyc),    32'(rx_pid),    32'(e_pid[cyc]));
      end
    end
  end

  task automatic clear_model(input int from);
    for (int c = from; c < NC; c++) begin
      e_rcv[c] = 1'b0;
      e_err[c] = 1'b0;
      e_wen[c] = 1'b0;
      e_pv[c]  = 1'b0;
      e_pid[c] = 4'h0;
    end
  endtask

  task automatic mid_reset();
    chk_en = 1'b0;
    #2;
    n_rst = 1'b0;
    #1;
    chk("rst_rcving",    32'(rcving),    32'h0);
    chk("rst_w_enable",  32'(w_enable),  32'h0);
    chk("rst_r_error",   32'(r_error),   32'h0);
    chk("rst_rx_pid",    32'(rx_pid),    32'h0);
    chk("rst_pid_valid", 32'(pid_valid), 32'h0);
    d_edge = 1'b0;
    shift_enable = 1'b0;
    eop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_hold_w_enable", 32'(w_enable), 32'h0);
      chk("rst_hold_rcving",   32'(rcving),   32'h0);
    end
    n_rst = 1'b1;
    clear_model(cyc);
    chk_en = 1'b1;
  endtask

  // Sends pkt[] as nb bits (LSB first per byte), then two SE0 bit times.
  // The expected timeline is derived from the packet before it is driven.
  task automatic send(input int nb, input bit spur, input int abort_bit);
    int td, e0, tz, err_t, pv_t, k;
    logic [7:0] sh;
    @(posedge clk); #1;
    td = cyc;
    e0 = sk(td, nb);
    tz = e0 + 2 * BITP;
    err_t = -1;
    pv_t = -1;
    cap.delete();
    wcnt = 0;
    pvcnt = 0;

    if (nb < 8) begin
      err_t = e0 + 1;
    end else if (pkt[0] != 8'h80) begin
      err_t = sk(td, 7) + 3;
    end else if (nb < 16) begin
      err_t = e0 + 1;
    end else if (pkt[1][3:0] != ~pkt[1][7:4]) begin
      err_t = sk(td, 15) + 3;
    end else begin
      pv_t = sk(td, 15) + 3;
      for (int j = 0; j < (nb - 16) / 8; j++) begin
        int se;
        se = sk(td, 16 + 8 * j + 7);
        if (j >= MAX) begin
          err_t = se + 3;
          break;
        end
        e_wen[se + 2] = 1'b1;
      end
      if (err_t < 0 && ((nb - 16) % 8) != 0) err_t = e0 + 1;
    end
    for (int c = td + 1; c < NC; c++) begin
      e_rcv[c] = (c <= tz);
      e_err[c] = (err_t >= 0) && (c >= err_t);
      if (pv_t >= 0 && c >= pv_t) e_pid[c] = pkt[1][3:0];
    end
    if (pv_t >= 0) e_pv[pv_t] = 1'b1;

    sh = 8'hFF;
    rcv_data = sh;
    for (int c = td; c <= tz + 6; c++) begin
      d_edge = (c == td) || (spur && c == sk(td, 20) + 2);
      shift_enable = 1'b0;
      if ((c - td - 4) >= 0 && ((c - td - 4) % BITP) == 0 && ((c - td - 4) / BITP) < nb)
        shift_enable = 1'b1;
      if (c == e0 || c == e0 + BITP) shift_enable = 1'b1;
      eop = (c >= e0) && (c < tz);
      if ((c - td - 5) >= 0 && ((c - td - 5) % BITP) == 0 && ((c - td - 5) / BITP) < nb) begin
        k = (c - td - 5) / BITP;
        sh = {pkt[k / 8][k % 8], sh[7:1]};
        rcv_data = sh;
      end
      if (abort_bit >= 0 && c == sk(td, abort_bit) + 1) begin
        mid_reset();
        return;
      end
      @(posedge clk); #1;
    end
    d_edge = 1'b0;
    shift_enable = 1'b0;
    eop = 1'b0;
    for (int j = 0; j < wcnt; j++)
      chk($sformatf("model_wdata%0d", j), 32'(cap[j]), 32'(pkt[2 + j]));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_model(0);
    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rcving",    32'(rcving),    32'h0);
    chk("reset_w_enable",  32'(w_enable),  32'h0);
    chk("reset_r_error",   32'(r_error),   32'h0);
    chk("reset_rx_pid",    32'(rx_pid),    32'h0);
    chk("reset_pid_valid", 32'(pid_valid), 32'h0);
    n_rst = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);

    // DATA0 with three bytes; a stray d_edge mid-packet must be ignored.
    pkt[0] = 8'h80; pkt[1] = 8'hC3; pkt[2] = 8'h11; pkt[3] = 8'h22; pkt[4] = 8'h33;
    send(40, 1'b1, -1);
    chk("data0_writes",  32'(wcnt),    32'd3);
    chk("data0_byte0",   32'(cap[0]),  32'h11);
    chk("data0_byte1",   32'(cap[1]),  32'h22);
    chk("data0_byte2",   32'(cap[2]),  32'h33);
    chk("data0_rx_pid",  32'(rx_pid),  32'h3);
    chk("data0_pidv",    32'(pvcnt),   32'd1);
    chk("data0_error",   32'(r_error), 32'h0);
    chk("data0_rcving",  32'(rcving),  32'h0);

    // Bad SYNC byte.
    pkt[0] = 8'h81; pkt[1] = 8'hC3; pkt[2] = 8'h55;
    send(24, 1'b0, -1);
    chk("badsync_error", 32'(r_error), 32'h1);
    chk("badsync_pidv",  32'(pvcnt),   32'd0);
    chk("badsync_wr",    32'(wcnt),    32'd0);
    chk("badsync_pid",   32'(rx_pid),  32'h3);

    // ACK handshake: no data, error cleared by the new packet.
    pkt[0] = 8'h80; pkt[1] = 8'hD2;
    send(16, 1'b0, -1);
    chk("ack_rx_pid", 32'(rx_pid),  32'h2);
    chk("ack_writes", 32'(wcnt),    32'd0);
    chk("ack_error",  32'(r_error), 32'h0);
    chk("ack_pidv",   32'(pvcnt),   32'd1);

    // PID check nibble mismatch.
    pkt[0] = 8'h80; pkt[1] = 8'hC4;
    send(16, 1'b0, -1);
    chk("badpid_error",  32'(r_error), 32'h1);
    chk("badpid_pidv",   32'(pvcnt),   32'd0);
    chk("badpid_writes", 32'(wcnt),    32'd0);
    chk("badpid_rx_pid", 32'(rx_pid),  32'h2);

    // One full data byte then EOP after five bits.
    pkt[0] = 8'h80; pkt[1] = 8'h4B; pkt[2] = 8'hA5; pkt[3] = 8'h0F;
    send(29, 1'b0, -1);
    chk("partial_writes", 32'(wcnt),    32'd1);
    chk("partial_byte0",  32'(cap[0]),  32'hA5);
    chk("partial_error",  32'(r_error), 32'h1);
    chk("partial_rx_pid", 32'(rx_pid),  32'hB);

    // Five data bytes against a four-byte limit.
    pkt[0] = 8'h80; pkt[1] = 8'hC3;
    pkt[2] = 8'h01; pkt[3] = 8'h02; pkt[4] = 8'h03; pkt[5] = 8'h04; pkt[6] = 8'h05;
    send(56, 1'b0, -1);
    chk("ovf_writes", 32'(wcnt),    32'd4);
    chk("ovf_byte3",  32'(cap[3]),  32'h04);
    chk("ovf_error",  32'(r_error), 32'h1);

    // Reset asserted one cycle before the second byte's write.
    pkt[0] = 8'h80; pkt[1] = 8'hC3; pkt[2] = 8'h11; pkt[3] = 8'h22; pkt[4] = 8'h33;
    send(40, 1'b0, 31);
    chk("abort_writes", 32'(wcnt), 32'd1);

    // Normal operation after the reset.
    pkt[0] = 8'h80; pkt[1] = 8'hD2;
    send(16, 1'b0, -1);
    chk("post_rst_rx_pid", 32'(rx_pid),  32'h2);
    chk("post_rst_error",  32'(r_error), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
